// File: rtl/lcd_pkg.sv
// Shared types and constants for the lcd_ctrl command feeder.
package lcd_pkg;

  localparam int unsigned ImgBytes = 36;
  localparam int unsigned WinPix   = 9;

  typedef enum logic [2:0] {
    CmdReflash = 3'd0,
    CmdLoad    = 3'd1,
    CmdRight   = 3'd2,
    CmdLeft    = 3'd3,
    CmdUp      = 3'd4,
    CmdDown    = 3'd5
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StStream,
    StWaitHi,
    StWaitLo
  } lcd_state_e;

  // First image-memory address of a bank; the largest bank base is 108, so 8 bits suffice.
  function automatic logic [7:0] img_base(input logic [1:0] bank);
    return 8'(bank) * 8'(ImgBytes);
  endfunction

endpackage

// File: rtl/lcd_cmd_feeder_if.sv
// Host command handshake into the feeder.
interface lcd_cmd_feeder_if;
  logic       h_valid;
  logic       h_ready;
  logic [2:0] h_cmd;
  logic [1:0] h_img;

  modport master (output h_valid, output h_cmd, output h_img, input h_ready);
  modport slave  (input h_valid, input h_cmd, input h_img, output h_ready);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding pending host commands; emptied by reset.
module lcd_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Issues buffered host commands to lcd_ctrl, streams Load images and checks the returned protocol.
module lcd_cmd_feeder
  import lcd_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned HiTimeout = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  lcd_cmd_feeder_if.slave        host_if,
  output logic                   img_re_o,
  output logic [7:0]             img_addr_o,
  input  logic [7:0]             img_rdata_i,
  output logic [2:0]             cmd_o,
  output logic                   cmd_valid_o,
  output logic [7:0]             datain_o,
  input  logic                   busy_i,
  input  logic                   output_valid_i,
  output logic                   done_o,
  output logic                   err_o
);

  logic [4:0] head;
  logic [2:0] head_cmd;
  logic [1:0] head_img;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;

  lcd_state_e state_q;
  logic [2:0] cmd_q;
  logic       cmd_valid_q, img_re_q, done_q, err_q;
  logic [7:0] addr_q;
  logic [5:0] byte_cnt_q;
  logic [3:0] pix_cnt_q, pix_cnt_d;
  logic [7:0] hi_cnt_q;

  assign host_if.h_ready = !fifo_full && !reset;
  assign fifo_push       = host_if.h_valid && host_if.h_ready;
  assign fifo_pop        = (state_q == StIdle) && !fifo_empty && !busy_i;
  assign head_cmd        = head[2:0];
  assign head_img        = head[4:3];

  lcd_cmd_fifo #(
    .Depth (FifoDepth),
    .Width (5)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i ({host_if.h_img, host_if.h_cmd}),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (output_valid_i && (pix_cnt_q != 4'hf)) pix_cnt_d = pix_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      img_re_q    <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      byte_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      hi_cnt_q    <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (output_valid_i && !(state_q inside {StStream, StWaitLo})) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            if (head_cmd > 3'(CmdDown)) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= StIssue;
              cmd_valid_q <= 1'b1;
              cmd_q       <= head_cmd;
              pix_cnt_q   <= '0;
              hi_cnt_q    <= '0;
              if (head_cmd == CmdLoad) begin
                img_re_q <= 1'b1;
                addr_q   <= img_base(head_img);
              end
            end
          end
        end
        StIssue: begin
          if (cmd_q == CmdLoad) begin
            state_q    <= StStream;
            byte_cnt_q <= '0;
            addr_q     <= addr_q + 8'd1;
          end else begin
            state_q <= StWaitHi;
          end
        end
        StStream: begin
          if (!busy_i) err_q <= 1'b1;
          byte_cnt_q <= byte_cnt_q + 6'd1;
          // Read-ahead ends one byte early: the last request was issued for byte 35.
          if (byte_cnt_q < 6'(ImgBytes - 2)) begin
            addr_q <= addr_q + 8'd1;
          end else begin
            img_re_q <= 1'b0;
            addr_q   <= '0;
          end
          if (byte_cnt_q == 6'(ImgBytes - 1)) state_q <= StWaitLo;
        end
        StWaitHi: begin
          if (busy_i) begin
            state_q <= StWaitLo;
          end else if (hi_cnt_q == 8'(HiTimeout - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            hi_cnt_q <= hi_cnt_q + 8'd1;
          end
        end
        StWaitLo: begin
          pix_cnt_q <= pix_cnt_d;
          if (!busy_i) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
            if (pix_cnt_d != 4'(WinPix)) err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign img_re_o    = img_re_q;
  assign img_addr_o  = addr_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign datain_o    = (state_q == StStream) ? img_rdata_i : 8'd0;

endmodule

// File: doc/lcd_cmd_feeder.md
Name: lcd_cmd_feeder

Overview:
- Upstream stage of lcd_ctrl: the host-side sequencer that feeds lcd_ctrl its commands and image bytes.
- Buffers host commands in a small FIFO and issues them to lcd_ctrl one at a time, honouring busy.
- For Load, streams one 36-byte 6x6 image from a synchronous image memory onto datain.
- Counts the output_valid pulses returned for each command and flags protocol errors.

Parameters:
- FIFO_DEPTH, 4, host command FIFO entries (power of 2).
- IMG_BYTES, 36, bytes per image (6x6).
- WIN_PIX, 9, output_valid pulses expected per command (3x3 window).
- HI_TIMEOUT, 4, cycles allowed for busy to rise after a non-Load issue.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- h_valid  in  1  host command valid.
- h_ready  out  1  FIFO can accept; equals !full; 0 while reset is asserted.
- h_cmd  in  3  command: 0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down.
- h_img  in  2  image bank for Load (ignored otherwise).
- img_re  out  1  image memory read enable.
- img_addr  out  8  image memory address = h_img*36 + byte index.
- img_rdata  in  8  image memory data, valid 1 cycle after img_re.
- cmd  out  3  to lcd_ctrl.
- cmd_valid  out  1  to lcd_ctrl; 1-cycle pulse.
- datain  out  8  to lcd_ctrl; img_rdata during STREAM, else 0.
- busy  in  1  from lcd_ctrl.
- output_valid  in  1  from lcd_ctrl.
- done  out  1  1-cycle pulse when a command completes.
- err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset: cmd_valid, cmd, img_re, img_addr, done and err are 0. FIFO is emptied and FSM goes to IDLE. This applies mid-operation too: the stream is abandoned and no further cmd_valid pulses are issued.
- FIFO push:
  - A push occurs when h_valid && h_ready.
  - Push and pop in the same cycle are legal when the FIFO is not full.
  - A write into an empty FIFO becomes issuable the following cycle.
- IDLE: when the FIFO is non-empty and busy==0, go to ISSUE.
  - If the head cmd is 6 or 7: pop it, set err, stay in IDLE; nothing is issued.
- ISSUE (1 cycle):
  - cmd_valid=1, cmd=head; pop the head; clear pix_cnt.
  - If Load: img_re=1, img_addr=base+0, next state STREAM, byte index k=0.
  - Otherwise: next state WAIT_HI.
- STREAM (exactly 36 cycles, k=0..35):
  - datain=img_rdata, which holds byte k.
  - For k<35: img_re=1, img_addr=base+k+1.
  - Byte 0 appears on datain the cycle after cmd_valid; bytes are contiguous with no gaps.
  - Then go to WAIT_LO.
- WAIT_HI:
  - Wait for busy==1, then go to WAIT_LO.
  - If busy is not seen within HI_TIMEOUT cycles: set err, go to IDLE, pulse done.
- WAIT_LO:
  - Count output_valid pulses in pix_cnt (4 bits, saturating at 15).
  - When busy==0 is sampled: pulse done; if pix_cnt!=WIN_PIX set err; go to IDLE.
  - The next ISSUE occurs no earlier than the cycle after done.
- output_valid outside WAIT_LO/STREAM sets err.
- busy==0 at any point during STREAM sets err; the stream still completes.
- Address arithmetic: 8-bit, max 3*36+35=143, no wrap.

Decomposition:
- Package lcd_pkg:
  - Command enum (CMD_REFLASH..CMD_DOWN).
  - IMG_BYTES=36, WIN_PIX=9.
  - FSM state typedef {IDLE, ISSUE, STREAM, WAIT_HI, WAIT_LO}.
- Sub-module lcd_cmd_fifo: synchronous FIFO with 5-bit data ({h_img,h_cmd}), full/empty, occupancy counter, flush on reset.
- Top module: FSM, address generator, pix_cnt, err/done.

Test Plan:
- Load h_img=2, memory byte=addr: cmd_valid at T, datain 72..107 on T+1..T+36, img_addr 72..107 on T..T+35; model busy high T+1..T+46 with 9 output_valid pulses -> done pulses once, err=0.
- Push Right, Up, Down back-to-back while busy=1 -> h_ready stays 1 (3 of 4 entries used); commands issue in order, each only after the previous done and with busy=0.
- Push 5 commands while busy is held high -> h_ready=0 after the 4th push; the 5th is held off; after one pop, h_ready=1 and the 5th is accepted.
- h_cmd=7 -> popped without a cmd_valid pulse, err=1; the following Reflash still issues normally.
- Model returns only 8 output_valid pulses -> done pulses, err=1; model never raises busy after Reflash -> err=1 after 4 cycles.
- reset asserted at stream byte 10 -> next cycle cmd_valid=0, img_re=0, FIFO empty, err=0, h_ready=1 after reset is released.
